data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_if.sv | 20 ++
 rtl/data_memory_ctrl.sv | 104 ++++++++++
 tb/tb_data_memory_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - datapath-to-data-memory request/response bundle
interface data_memory_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        misaligned;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, stall, misaligned
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, stall, misaligned
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - multi-cycle data memory with stall handshake
// Optional DMEM_ALIGN_CHECK_EN: misaligned accesses are rejected in one cycle.
module data_memory_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    data_memory_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [AW-1:0]  idx_q;
    logic [31:0]    data_q;
    logic           write_q;
    logic [31:0]    read_data_q;
    logic           misaligned_q;
    logic [31:0]    mem [DEPTH];

    logic           req;
    logic           bad_align;
    logic           fire;
    logic [AW-1:0]  acc_idx;
    logic [31:0]    acc_data;
    logic           acc_write;

    assign req = bus.mem_read | bus.mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad_align = |bus.addr[1:0];
`else
    assign bad_align = 1'b0;
`endif

    // With zero wait cycles the access completes straight out of IDLE, so the
    // live inputs stand in for the not-yet-latched copies.
    assign acc_idx   = (state == IDLE) ? bus.addr[AW+1:2] : idx_q;
    assign acc_data  = (state == IDLE) ? bus.write_data   : data_q;
    assign acc_write = (state == IDLE) ? bus.mem_write    : write_q;

    assign fire = ((state == BUSY) && (cnt == 4'd0)) ||
                  ((state == IDLE) && req && !bad_align && (WAIT_CYCLES == 0));

    assign bus.stall      = ((state == IDLE) && req && !reset) || (state == BUSY);
    assign bus.read_data  = read_data_q;
    assign bus.misaligned = misaligned_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            idx_q        <= '0;
            data_q       <= 32'd0;
            write_q      <= 1'b0;
            read_data_q  <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            if (fire && !acc_write) begin
                read_data_q <= mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= bus.addr[AW+1:2];
                        data_q  <= bus.write_data;
                        write_q <= bus.mem_write;
                        if (bad_align) begin
                            state        <= DONE;
                            misaligned_q <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The array has no reset so contents survive a processor reset; only the
    // write strobe is gated, which is what aborts an in-flight store.
    always_ff @(posedge clk) begin
        if (!reset && fire && acc_write) begin
            mem[acc_idx] <= acc_data;
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    data_memory_ctrl_if bus ();
    data_memory_ctrl_if bus0 ();

    data_memory_ctrl #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    data_memory_ctrl #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus.mem_read = rd; bus.mem_write = wr; bus.addr = a; bus.write_data = d;
        end else begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.write_data = d;
        end
    endtask

    // Holds the request until the first cycle with stall low (the DONE cycle),
    // samples there, then drops the request in the following IDLE cycle.
    task automatic access(input int which, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output int lat,
                          output logic [31:0] rdata, output logic mis);
        bit done;
        logic s;
        @(posedge clk); #1;
        drive(which, rd, wr, a, d);
        stalls = 0; lat = 0; done = 0; rdata = 32'd0; mis = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            s = (which == 0) ? bus.stall : bus0.stall;
            if (s) begin
                stalls++;
            end else begin
                done  = 1;
                lat   = n + 1;
                rdata = (which == 0) ? bus.read_data : bus0.read_data;
                mis   = (which == 0) ? bus.misaligned : bus0.misaligned;
            end
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(which, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    int          st, lt;
    logic [31:0] rd;
    logic        ms;
    bit          done;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_mis", {31'd0, bus.misaligned}, 32'd0);
        check("rst_rdata", bus.read_data, 32'd0);

        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, lt, rd, ms);
        check("sw_stall", st, 3);
        check("sw_lat", lt, 4);
        check("sw_mis", {31'd0, ms}, 32'd0);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, st, lt, rd, ms);
        check("lw_stall", st, 3);
        check("lw_lat", lt, 4);
        check("lw_data", rd, 32'hDEADBEEF);

        access(0, 1'b0, 1'b1, 32'h400, 32'h11111111, st, lt, rd, ms);
        access(0, 1'b1, 1'b0, 32'h000, 32'd0, st, lt, rd, ms);
        check("wrap_lo", rd, 32'h11111111);
        access(0, 1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, st, lt, rd, ms);
        access(0, 1'b1, 1'b0, 32'h7FC, 32'd0, st, lt, rd, ms);
        check("wrap_hi", rd, 32'hCAFEF00D);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, st, lt, rd, ms);
        check("wrap_no_alias", rd, 32'hDEADBEEF);

        access(0, 1'b1, 1'b1, 32'h8, 32'h5, st, lt, rd, ms);
        check("both_rdata_kept", rd, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h8, 32'd0, st, lt, rd, ms);
        check("both_wrote", rd, 32'h5);

        // Inputs change after the access has been latched.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h30, 32'h77);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h8, 32'h99);
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (!bus.stall) done = 1;
        end
        if (!done) check("busy_change_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        access(0, 1'b1, 1'b0, 32'h30, 32'd0, st, lt, rd, ms);
        check("busy_change_latched", rd, 32'h77);
        access(0, 1'b1, 1'b0, 32'h8, 32'd0, st, lt, rd, ms);
        check("busy_change_ignored", rd, 32'h5);

        // Reset in the second BUSY cycle of a store must abort it.
        access(0, 1'b0, 1'b1, 32'h20, 32'h12345678, st, lt, rd, ms);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_stall", {31'd0, bus.stall}, 32'd0);
        check("abort_rdata_clr", bus.read_data, 32'd0);
        access(0, 1'b1, 1'b0, 32'h20, 32'd0, st, lt, rd, ms);
        check("abort_kept", rd, 32'h12345678);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, st, lt, rd, ms);
        check("reset_keeps_mem", rd, 32'hDEADBEEF);

        access(1, 1'b0, 1'b1, 32'h4, 32'h99, st, lt, rd, ms);
        check("wc0_sw_stall", st, 1);
        check("wc0_sw_lat", lt, 2);
        access(1, 1'b1, 1'b0, 32'h4, 32'd0, st, lt, rd, ms);
        check("wc0_lw_stall", st, 1);
        check("wc0_lw_lat", lt, 2);
        check("wc0_lw_data", rd, 32'h99);

        access(0, 1'b0, 1'b1, 32'h13, 32'h0BADF00D, st, lt, rd, ms);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_flag", {31'd0, ms}, 32'd1);
        check("mis_stall", st, 1);
        check("mis_lat", lt, 2);
        check("mis_rdata_kept", rd, 32'hDEADBEEF);
        @(negedge clk);
        check("mis_one_cycle", {31'd0, bus.misaligned}, 32'd0);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, st, lt, rd, ms);
        check("mis_no_write", rd, 32'hDEADBEEF);
`else
        check("mis_flag_off", {31'd0, ms}, 32'd0);
        check("mis_stall_off", st, 3);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, st, lt, rd, ms);
        check("mis_low_bits_ignored", rd, 32'h0BADF00D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
